cla5_slice_sequencer: RTL and testbench
=======================================

// Module: cla5_slice_sequencer
// PURPOSE
//  Wide-operand front end for the 5-bit CLA slice adder (cla5bit). Accepts a
//  WIDTH-bit A/B/Cin operation over valid/ready and feeds it to one external
//  cla5bit instance as 5-bit slices, LSB slice first, one slice per cycle.
//  The carry is registered from slice to slice. Sum slices are reassembled
//  and the result is presented over valid/ready.
// PARAMETERS
//  SLICES  4  number of 5-bit slices; WIDTH = 5*SLICES (default 20); legal >= 1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset: synchronous, active-high
//  in_valid   in   1      operation request
//  in_ready   out  1      high only in IDLE and when rst=0
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in to slice 0
//  cla_a      out  5      slice of A to adder
//  cla_b      out  5      slice of B to adder
//  cla_cin    out  1      carry into adder
//  cla_sum    in   5      adder sum (combinational return, same cycle)
//  cla_cout   in   1      adder carry-out (same cycle)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  A+B+Cin mod 2^WIDTH
//  out_cout   out  1      carry out of top slice
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, idx=0, carry=0.
//   Outputs out_valid, out_sum and out_cout are 0.
//   Operand registers are cleared. Reset overrides any in-flight operation.
//   No partial result is emitted.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. On in_valid & in_ready, capture in_a, in_b and in_cin.
//   Set idx=0 and carry=in_cin, then go to RUN.
//  RUN: cla_a=A[5*idx+:5], cla_b=B[5*idx+:5], cla_cin=carry.
//   At each edge: out_sum[5*idx+:5] <= cla_sum; carry <= cla_cout.
//   If idx==SLICES-1: out_cout <= cla_cout and go to DONE. Otherwise idx++.
//  DONE: out_valid=1. out_sum and out_cout are held stable until
//   out_valid & out_ready. On that handshake go to IDLE and out_valid falls
//   next cycle.
//  Outside RUN: cla_a=0, cla_b=0, cla_cin=0.
//  Latency: accept at edge T; RUN for SLICES cycles; out_valid rises at edge
//   T+SLICES. Minimum spacing between accepts is SLICES+2 cycles.
//   There is no overlap: in_ready is low in DONE even when out_ready=1.
//  in_valid while busy: ignored. No state change, nothing latched.
//  Operands: changes on in_a/in_b after accept have no effect (registered).
//  Width rules: out_sum is exactly WIDTH bits. Overflow is reported only via
//   out_cout. Results wrap modulo 2^WIDTH.
//  SLICES=1: RUN lasts exactly one cycle. idx is a constant 0.
//  out_sum bits above the current slice during RUN hold stale data.
//   They are valid only when out_valid=1.
// TESTING (SLICES=4, real cla5bit attached)
//  1. A=0xFFFFF, B=0x00001, cin=0 -> out_sum=0x00000, out_cout=1.
//     out_valid 4 cycles after the accept edge.
//  2. A=0x12345, B=0x0ABCD, cin=1 -> out_sum=0x1CF13, out_cout=0.
//     cla_cin=1 on slice 0.
//  3. Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1.
//     out_sum and out_cout stay stable and in_ready=0. Release -> IDLE next cycle.
//  4. in_valid held high with new operands during RUN/DONE -> not captured.
//     The result matches the first operation only.
//  5. rst=1 in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, out_sum=0.
//     The following op A=0x00010, B=0x00020 gives 0x00030.
//  6. 1000 random ops, random in_valid/out_ready -> all match (A+B+cin)
//     reference. cla_* ports are 0 whenever the FSM is not in RUN.

Source files
------------

// File: rtl/cla5_slice_sequencer.sv
// Wide-operand front end for an external 5-bit CLA slice adder.
// Walks the operands LSB slice first, one slice per cycle, and returns the reassembled sum over valid/ready.
module cla5_slice_sequencer #(
  parameter  int SLICES = 4,
  localparam int WIDTH  = 5 * SLICES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [4:0]       cla_a,
  output logic [4:0]       cla_b,
  output logic             cla_cin,
  input  logic [4:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             accept;
  int               base;

  assign base = 5 * int'(idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cla_a     = 5'd0;
    cla_b     = 5'd0;
    cla_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        cla_a   = a_reg[base +: 5];
        cla_b   = b_reg[base +: 5];
        cla_cin = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched at accept so later input changes cannot disturb the slice walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry <= in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_reg[base +: 5] <= cla_sum;
      carry              <= cla_cout;
      if (idx == LAST) cout_reg <= cla_cout;
      else             idx      <= idx + 1'b1;
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;

endmodule

// File: tb/tb_cla5_slice_sequencer.sv
// Bench for cla5_slice_sequencer with a behavioural 5-bit adder attached.
// Directed cases plus randomized traffic against a queue-based A+B+cin reference.
module tb_cla5_slice_sequencer;

  localparam int SLICES = 4;
  localparam int WIDTH  = 5 * SLICES;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [4:0]       cla_a;
  logic [4:0]       cla_b;
  logic             cla_cin;
  logic [4:0]       cla_sum;
  logic             cla_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  cla5_slice_sequencer #(.SLICES(SLICES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external cla5bit slice adder.
  assign {cla_cout, cla_sum} = 6'(cla_a) + 6'(cla_b) + 6'(cla_cin);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    #1;
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      step();
      cycles++;
    end
    if (!out_valid) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int              n;
    logic [WIDTH:0]  expq[$];
    int              acceptCycle[$];
    logic [WIDTH:0]  exp_v;
    int              cycle;
    int              done;
    bit              prevValid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;

    step();
    step();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    // Full-width carry ripple and latency
    applyStimulus(20'hFFFFF, 20'h00001, 1'b0);
    waitResult(n);
    checkOutput("t1_latency", 32'(n), 32'(SLICES));
    checkOutput("t1_sum", 32'(out_sum), 32'h00000);
    checkOutput("t1_cout", 32'(out_cout), 32'd1);
    out_ready = 1'b1;
    step();
    checkOutput("t1_valid_fall", 32'(out_valid), 32'd0);
    checkOutput("t1_idle_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Carry-in feeds slice 0
    applyStimulus(20'h12345, 20'h0ABCD, 1'b1);
    checkOutput("t2_cla_cin", 32'(cla_cin), 32'd1);
    checkOutput("t2_cla_a", 32'(cla_a), 32'h05);
    checkOutput("t2_cla_b", 32'(cla_b), 32'h0D);
    waitResult(n);
    checkOutput("t2_sum", 32'(out_sum), 32'h1CF13);
    checkOutput("t2_cout", 32'(out_cout), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure with in_valid held high on fresh operands
    applyStimulus(20'hABCDE, 20'h54322, 1'b0);
    in_valid = 1'b1;
    in_a     = 20'h11111;
    in_b     = 20'h22222;
    waitResult(n);
    for (int i = 0; i < 10; i++) begin
      step();
      in_a = WIDTH'($urandom);
      in_b = WIDTH'($urandom);
      #1;
      checkOutput("t3_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t3_hold_sum", 32'(out_sum), 32'h00000);
      checkOutput("t3_hold_cout", 32'(out_cout), 32'd1);
      checkOutput("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("t3_release_valid", 32'(out_valid), 32'd0);
    checkOutput("t3_release_busy", 32'(busy), 32'd0);
    checkOutput("t3_release_ready", 32'(in_ready), 32'd1);

    // Reset in the second RUN cycle
    applyStimulus(20'h55555, 20'h33333, 1'b1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_rst_sum", 32'(out_sum), 32'd0);
    checkOutput("t5_rst_cout", 32'(out_cout), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_after_rst_ready", 32'(in_ready), 32'd1);
    applyStimulus(20'h00010, 20'h00020, 1'b0);
    waitResult(n);
    checkOutput("t5_sum", 32'(out_sum), 32'h00030);
    checkOutput("t5_cout", 32'(out_cout), 32'd0);
    step();

    // Randomized traffic against the reference queue
    cycle     = 0;
    done      = 0;
    prevValid = 1'b0;
    while (done < 1000 && cycle < 30000) begin
      step();
      cycle++;
      in_valid  = ($urandom_range(3) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_cin    = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(!busy));
      if (!(busy && !out_valid))
        checkOutput("rnd_cla_idle_zero", 32'({cla_a, cla_b, cla_cin}), 32'd0);
      if (out_valid && !prevValid) begin
        if (acceptCycle.size() == 0) checkOutput("rnd_spurious_valid", 32'd1, 32'd0);
        else checkOutput("rnd_latency", 32'(cycle - acceptCycle.pop_front()), 32'(SLICES));
      end
      prevValid = out_valid;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("rnd_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_v = expq.pop_front();
          checkOutput("rnd_sum", 32'(out_sum), 32'(exp_v[WIDTH-1:0]));
          checkOutput("rnd_cout", 32'(out_cout), 32'(exp_v[WIDTH]));
          done++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(refAdd(in_a, in_b, in_cin));
        acceptCycle.push_back(cycle + 1);
      end
    end
    if (done < 1000) checkOutput("rnd_ops_done", 32'(done), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
